// File: rtl/reg_disp_pkg.sv
// Shared definitions for the register display scanner: capture FSM states,
// digit count and the seven-segment font (active low, bit order g..a).
package reg_disp_pkg;

    localparam int DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2
    } cap_state_t;

    // Index is the nibble value; each entry is seg_n[6:0] = g..a, low = lit.
    localparam logic [6:0] SEG_FONT [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import reg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Straight font lookup; the caller registers the result.
    assign seg_n = SEG_FONT[nibble];

endmodule

// File: rtl/reg_display_scan.sv
// Debug register readout: once per display frame the register chosen by
// reg_sel is fetched through the synchronous debug port into a shadow copy,
// which is scanned out as eight hex digits on a multiplexed active-low
// seven-segment display.
// Optional feature: define REG_DISP_LZB_EN for leading-zero blanking.
module reg_display_scan
    import reg_disp_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg_sel,
    input  logic        freeze,
    output logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [2:0]    digit;
    logic          first;
    logic          tick;
    logic          frame_start;
    logic          slot_start;
    cap_state_t    state;
    logic [31:0]   shadow;
    logic          frozen;
    logic [3:0]    nibble;
    logic [6:0]    font_seg;
    logic          digit_on;

    assign tick        = (presc == PRESC_LAST);
    // The first cycle after reset release starts a frame so the display
    // is filled without waiting a whole refresh period.
    assign frame_start = first | (tick & (digit == 3'd7));
    assign slot_start  = (presc == '0);

    // Digit slot timer and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= 3'd0;
        end else if (tick) begin
            presc <= '0;
            digit <= digit + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Marks the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first <= 1'b1;
        end else begin
            first <= 1'b0;
        end
    end

    // Capture FSM: address in the frame-start cycle, one wait cycle for the
    // read port, then latch the data (x0 forced to zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dbg_addr <= 5'd0;
            shadow   <= 32'd0;
            frozen   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        frozen <= freeze;
                        if (!freeze) begin
                            dbg_addr <= reg_sel;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: state <= ST_CAPT;
                ST_CAPT: begin
                    shadow <= (dbg_addr == 5'd0) ? 32'd0 : dbg_data;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign nibble = shadow[{digit, 2'b00} +: 4];

    hex_to_seg7 u_font (
        .nibble (nibble),
        .seg_n  (font_seg)
    );

`ifdef REG_DISP_LZB_EN
    logic [2:0] lead;

    // Position of the most significant nonzero nibble (0 when shadow is 0).
    always_comb begin
        lead = 3'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (shadow[4*i +: 4] != 4'h0) begin
                lead = 3'(i);
            end
        end
    end

    // Digit 7 stays lit while frozen so the decimal point remains visible.
    assign digit_on = (digit <= lead) | ((digit == 3'd7) & frozen);
`else
    assign digit_on = 1'b1;
`endif

    // Registered display drive; the first cycle of each slot is blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 8'hFF;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= (slot_start || !digit_on) ? 8'hFF : ~(8'h01 << digit);
            seg_n <= font_seg;
            dp_n  <= ~((digit == 3'd7) & frozen & ~slot_start);
        end
    end

endmodule

// File: tb/tb_reg_display_scan.sv
// Bench for reg_display_scan with DIGIT_CYCLES=4. A cycle-count based model
// predicts every output each cycle; a vector table checks whole frames
// decoded back into words.
module tb_reg_display_scan;

    localparam int DC    = 4;
    localparam int FRAME = 8 * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  reg_sel = 5'd5;
    logic        freeze = 1'b0;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data = 32'd0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    logic [31:0] rf [32];
    logic [6:0]  font_tb [16];

    int n_tests = 0;
    int n_fail  = 0;

    longint      s;
    logic [31:0] m_shadow;
    logic        m_frozen;
    logic [4:0]  m_addr;
    longint      cap_edge;
    logic [31:0] cap_val;

    typedef struct {
        logic [4:0]  sel;
        logic        frz;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [9];

    reg_display_scan #(.DIGIT_CYCLES(DC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg_sel  (reg_sel),
        .freeze   (freeze),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    // Synchronous debug read port of the core's register file.
    always @(posedge clk) dbg_data <= rf[dbg_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (s=%0d)", name, act, exp, s);
        end
    endtask

    function automatic bit is_fs(input longint t);
        return (t == 0) || ((t % FRAME) == FRAME - 1);
    endfunction

    function automatic int lead_of(input logic [31:0] w);
        int l = 0;
        for (int i = 0; i < 8; i++) if (((w >> (4 * i)) & 32'hF) != 0) l = i;
        return l;
    endfunction

    function automatic logic [7:0] exp_mask(input logic [31:0] w, input logic frz);
        logic [7:0] m;
`ifdef REG_DISP_LZB_EN
        m = 8'h00;
        for (int i = 0; i <= lead_of(w); i++) m[i] = 1'b1;
        if (frz) m[7] = 1'b1;
`else
        m = 8'hFF;
        if (frz) m = 8'hFF;
        if (w == 32'd0) m = 8'hFF;
`endif
        return m;
    endfunction

    function automatic int seg2hex(input logic [6:0] sg);
        for (int i = 0; i < 16; i++) if (font_tb[i] == sg) return i;
        return -1;
    endfunction

    task automatic model_reset();
        s        = 0;
        m_shadow = 32'd0;
        m_frozen = 1'b0;
        m_addr   = 5'd0;
        cap_edge = -1;
        cap_val  = 32'd0;
    endtask

    // One clock: predict outputs from the model state before the edge,
    // advance the model, then compare.
    task automatic step();
        int         dg;
        int         ct;
        bit         vis;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [4:0] n_addr;
        logic       n_frozen;
        dg = int'((s / DC) % 8);
        ct = int'(s % DC);
        vis = 1'b1;
`ifdef REG_DISP_LZB_EN
        vis = (dg <= lead_of(m_shadow)) || (dg == 7 && m_frozen);
`endif
        e_an  = (ct == 0 || !vis) ? 8'hFF : ~(8'h01 << dg);
        e_seg = font_tb[(m_shadow >> (4 * dg)) & 32'hF];
        e_dp  = !(dg == 7 && m_frozen && ct != 0);
        n_addr   = m_addr;
        n_frozen = m_frozen;
        if (is_fs(s)) begin
            n_frozen = freeze;
            if (!freeze) begin
                n_addr   = reg_sel;
                cap_edge = s + 3;
                cap_val  = (reg_sel == 5'd0) ? 32'd0 : rf[reg_sel];
            end
        end
        @(posedge clk);
        s++;
        m_addr   = n_addr;
        m_frozen = n_frozen;
        if (s == cap_edge) m_shadow = cap_val;
        #1;
        check("an_n", {24'd0, an_n}, {24'd0, e_an});
        if (e_an != 8'hFF) check("seg_n", {25'd0, seg_n}, {25'd0, e_seg});
        check("dp_n", {31'd0, dp_n}, {31'd0, e_dp});
        check("dbg_addr", {27'd0, dbg_addr}, {27'd0, m_addr});
    endtask

    task automatic wait_fs();
        int guard = 0;
        while (!is_fs(s) && guard < FRAME + 2) begin
            step();
            guard++;
        end
        check("fs_reached", {31'd0, is_fs(s)}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an_n"}, {24'd0, an_n}, 32'hFF);
        check({tag, "_seg_n"}, {25'd0, seg_n}, 32'h7F);
        check({tag, "_dp_n"}, {31'd0, dp_n}, 32'd1);
        check({tag, "_dbg_addr"}, {27'd0, dbg_addr}, 32'd0);
    endtask

    initial begin
        logic [31:0] word;
        logic [7:0]  shown;
        int          h;
        int          guard;

        font_tb = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0]  = 32'hFFFFFFFF;
        rf[3]  = 32'h000000A3;
        rf[5]  = 32'h1234ABCD;
        rf[9]  = 32'hDEADBEEF;
        rf[12] = 32'h00000000;
        rf[17] = 32'h80000001;

        vecs[0] = '{5'd5,  1'b0, 32'h1234ABCD};
        vecs[1] = '{5'd0,  1'b0, 32'h00000000};
        vecs[2] = '{5'd9,  1'b0, 32'hDEADBEEF};
        vecs[3] = '{5'd3,  1'b1, 32'hDEADBEEF};
        vecs[4] = '{5'd3,  1'b0, 32'h000000A3};
        vecs[5] = '{5'd17, 1'b0, 32'h80000001};
        vecs[6] = '{5'd12, 1'b0, 32'h00000000};
        vecs[7] = '{5'd5,  1'b1, 32'h00000000};
        vecs[8] = '{5'd5,  1'b0, 32'h1234ABCD};

        // Reset state.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Whole-frame vectors.
        for (int v = 0; v < 9; v++) begin
            reg_sel = vecs[v].sel;
            freeze  = vecs[v].frz;
            wait_fs();
            step();
            if (v == 0) check("addr_after_release", {27'd0, dbg_addr}, 32'd5);
            word  = 32'd0;
            shown = 8'h00;
            for (int c = 0; c < FRAME; c++) begin
                step();
                for (int i = 0; i < 8; i++) begin
                    if (an_n == ~(8'h01 << i)) begin
                        shown[i] = 1'b1;
                        h = seg2hex(seg_n);
                        word[4*i +: 4] = (h < 0) ? 4'hF : 4'(h);
                    end
                end
            end
            check($sformatf("frame_word_%0d", v), word, vecs[v].word);
            check($sformatf("frame_mask_%0d", v), {24'd0, shown},
                  {24'd0, exp_mask(vecs[v].word, vecs[v].frz)});
        end

        // reg_sel change mid-frame takes effect only at the next frame start.
        repeat (5) step();
        reg_sel = 5'd9;
        repeat (20) step();
        check("midframe_addr_hold", {27'd0, dbg_addr}, 32'd5);
        wait_fs();
        repeat (4) step();
        check("nextframe_addr", {27'd0, dbg_addr}, 32'd9);

        // Reset asserted while the capture waits on the read port.
        wait_fs();
        reg_sel = 5'd17;
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midcap");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midcap_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) step();

        // Randomised run against the model.
        guard = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if ($urandom_range(0, 19) == 0) reg_sel = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 39) == 0) freeze = ~freeze;
            guard++;
        end
        check("random_cycles_done", guard, 32'd600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
